// File: rtl/legv8_fetch_pkg.sv
// Shared types for the LEGv8 fetch unit: branch-type codes, fetch FSM states, widths.
package legv8_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int OFFS_W  = 26;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch resolution: decides taken and computes br_pc + (sext(offset) << 2).
module branch_target_calc
    import legv8_fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [1:0]        br_type_i,
    input  logic [OFFS_W-1:0] br_offset_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic              br_zero_i,
    output logic              taken_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [ADDR_W-1:0] offs_sext;

    // CBZ/CBNZ carry a 19-bit offset; the upper offset bits are ignored for them.
    always_comb begin
        taken_o   = 1'b0;
        offs_sext = {{(ADDR_W-19){br_offset_i[18]}}, br_offset_i[18:0]};
        case (br_type_e'(br_type_i))
            BR_B: begin
                taken_o   = 1'b1;
                offs_sext = {{(ADDR_W-OFFS_W){br_offset_i[OFFS_W-1]}}, br_offset_i};
            end
            BR_CBZ:  taken_o = br_zero_i;
            BR_CBNZ: taken_o = !br_zero_i;
            default: taken_o = 1'b0;
        endcase
    end

    assign target_o = br_pc_i + (offs_sext << 2);

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch unit: PC, req/ack instruction fetch, valid/ready to decode, branch redirect.
// Optional BRANCH_LINK_EN adds br_link_i / link_we_o / link_data_o for BL.
module legv8_fetch_unit
    import legv8_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // Fetch handshake: imem_req_o stays high with a stable address until imem_ack_i.
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [31:0]        imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               br_valid_i,
    input  logic [1:0]         br_type_i,
    input  logic [ADDR_W-1:0]  br_pc_i,
    input  logic [25:0]        br_offset_i,
    input  logic               br_zero_i,
    output logic               redirect_o,
`ifdef BRANCH_LINK_EN
    input  logic               br_link_i,
    output logic               link_we_o,
    output logic [ADDR_W-1:0]  link_data_o,
`endif
    output logic [1:0]         state_o
);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                kill_q;
    logic                imem_req_q;
    logic                instr_valid_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   instr_pc_q;
    logic                redirect_q;

    logic                br_taken;
    logic [ADDR_W-1:0]   br_target;
    logic                redirect_d;

    branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
        .br_type_i   (br_type_i),
        .br_offset_i (br_offset_i),
        .br_pc_i     (br_pc_i),
        .br_zero_i   (br_zero_i),
        .taken_o     (br_taken),
        .target_o    (br_target)
    );

    assign redirect_d = br_valid_i && br_taken && (state_q != S_IDLE);

    // addr_q is the address of the outstanding request; pc_q may move ahead of it while kill_q is set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            redirect_q    <= 1'b0;
        end else begin
            redirect_q <= redirect_d;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                    addr_q     <= pc_q;
                end
                S_REQ: begin
                    if (imem_ack_i) begin
                        if (kill_q || redirect_d) begin
                            kill_q <= 1'b0;
                            pc_q   <= redirect_d ? br_target : pc_q;
                            addr_q <= redirect_d ? br_target : pc_q;
                        end else begin
                            instr_q       <= imem_rdata_i;
                            instr_pc_q    <= addr_q;
                            pc_q          <= addr_q + ADDR_W'(4);
                            state_q       <= S_HOLD;
                            imem_req_q    <= 1'b0;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (redirect_d) begin
                        pc_q   <= br_target;
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_d || instr_ready_i) begin
                        state_q       <= S_REQ;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                        pc_q          <= redirect_d ? br_target : pc_q;
                        addr_q        <= redirect_d ? br_target : pc_q;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_LINK_EN
    logic              link_we_q;
    logic [ADDR_W-1:0] link_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_we_q   <= redirect_d && (br_type_e'(br_type_i) == BR_B) && br_link_i;
            link_data_q <= (redirect_d && (br_type_e'(br_type_i) == BR_B) && br_link_i)
                           ? br_pc_i + ADDR_W'(4) : '0;
        end
    end

    assign link_we_o   = link_we_q;
    assign link_data_o = link_data_q;
`endif

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign redirect_o    = redirect_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit: variable-latency memory responder, stream-level
// reference model (expected next delivered PC), directed scenarios and a randomized run.
module tb_legv8_fetch_unit;

  localparam int          ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h100;

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        br_valid_i;
  logic [1:0]  br_type_i;
  logic [63:0] br_pc_i;
  logic [25:0] br_offset_i;
  logic        br_zero_i;
  logic        redirect_o;
  logic [1:0]  state_o;
`ifdef BRANCH_LINK_EN
  logic        br_link_i;
  logic        link_we_o;
  logic [63:0] link_data_o;
`endif

  legv8_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .br_valid_i    (br_valid_i),
    .br_type_i     (br_type_i),
    .br_pc_i       (br_pc_i),
    .br_offset_i   (br_offset_i),
    .br_zero_i     (br_zero_i),
    .redirect_o    (redirect_o),
`ifdef BRANCH_LINK_EN
    .br_link_i     (br_link_i),
    .link_we_o     (link_we_o),
    .link_data_o   (link_data_o),
`endif
    .state_o       (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int          n_cmp;
  int          n_err;
  int          n_hs;
  logic [63:0] exp_q[$];
  int          lat_min;
  int          lat_max;
  bit          force_ack;
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  bit          in_idle;
  bit          prev_taken;
  bit          prev_hold;
  logic [31:0] prev_instr;
  logic [63:0] prev_pc;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit ref_taken(input logic [1:0] t, input logic z);
    case (t)
      2'b01:   return 1'b1;
      2'b10:   return z;
      2'b11:   return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] ref_target(input logic [1:0] t, input logic [63:0] pc,
                                             input logic [25:0] off);
    longint words;
    logic [18:0] off19;
    off19 = off[18:0];
    if (t == 2'b01)
      words = (off >= 26'h2000000) ? longint'(off) - 64'sd67108864 : longint'(off);
    else
      words = (off19 >= 19'h40000) ? longint'(off19) - 64'sd524288 : longint'(off19);
    return pc + 64'(words * 4);
  endfunction

  // ---------------- memory responder (negedge + 1) ----------------
  always @(negedge clk) begin
    #1;
    imem_ack_i = 1'b0;
    if (force_ack) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF;
    end else if (rst_i || !imem_req_o) begin
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end else begin
        n_cmp++;
        if (imem_addr_o !== mem_addr) begin
          n_err++;
          $display("FAIL imem_addr_stable: got %h required %h", imem_addr_o, mem_addr);
        end
      end
      if (mem_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(mem_addr);
        mem_busy     = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  // ---------------- scoreboard monitor (negedge + 2) ----------------
  always @(negedge clk) begin
    logic [63:0] nxt;
    bit          taken;
    #2;
    if (rst_i) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      in_idle    = 1'b1;
      prev_taken = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      n_cmp++;
      if (redirect_o !== prev_taken) begin
        n_err++;
        $display("FAIL redirect_pulse: got %b required %b", redirect_o, prev_taken);
      end
      if (prev_hold) begin
        n_cmp++;
        if (instr_valid_o !== 1'b1 || instr_o !== prev_instr || instr_pc_o !== prev_pc) begin
          n_err++;
          $display("FAIL hold_stable: got v=%b %h@%h required v=1 %h@%h",
                   instr_valid_o, instr_o, instr_pc_o, prev_instr, prev_pc);
        end
      end
      if (instr_valid_o && instr_ready_i) begin
        n_cmp++;
        if (instr_pc_o !== exp_q[0] || instr_o !== mem_word(exp_q[0])) begin
          n_err++;
          $display("FAIL delivered_instr: got %h@%h required %h@%h",
                   instr_o, instr_pc_o, mem_word(exp_q[0]), exp_q[0]);
        end
        n_hs++;
        nxt = exp_q.pop_front() + 64'd4;
        exp_q.push_back(nxt);
      end
      taken = !in_idle && br_valid_i && ref_taken(br_type_i, br_zero_i);
      if (taken) begin
        exp_q.delete();
        exp_q.push_back(ref_target(br_type_i, br_pc_i, br_offset_i));
      end
      prev_taken = taken;
      prev_hold  = instr_valid_o && !instr_ready_i && !taken;
      prev_instr = instr_o;
      prev_pc    = instr_pc_o;
      in_idle    = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rdy, input bit bv, input logic [1:0] bt,
                       input logic [63:0] bpc, input logic [25:0] boff, input bit bz);
    instr_ready_i = rdy;
    br_valid_i    = bv;
    br_type_i     = bt;
    br_pc_i       = bpc;
    br_offset_i   = boff;
    br_zero_i     = bz;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_pending(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (imem_req_o === 1'b1 && mem_busy && mem_cnt > 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    lat_min = 0; lat_max = 0;
    tick();
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    tick();
    tick();
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b required 0", imem_req_o); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", instr_valid_o); end
    n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b required 0", redirect_o); end
    n_cmp++; if (instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h required 0", instr_o); end
    n_cmp++; if (instr_pc_o !== 64'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h required 0", instr_pc_o); end
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h required req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] got[$];
    for (int i = 0; i < 30 && got.size() < 3; i++) begin
      if (imem_req_o === 1'b1) got.push_back(imem_addr_o);
      tick();
    end
    n_cmp++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL seq_req_count: got %0d required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== RESET_PC + 64'(4 * i)) begin
          n_err++;
          $display("FAIL seq_addr%0d: got %h required %h", i, got[i], RESET_PC + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [31:0] i0;
    logic [63:0] p0;
    lat_min = 3; lat_max = 3;
    drive(1'b0, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(30, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_wait: got timeout required valid"); end
    i0 = instr_o; p0 = instr_pc_o;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== i0 || imem_req_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got v=%b instr=%h req=%b required v=1 instr=%h req=0",
                 c, instr_valid_o, instr_o, imem_req_o, i0);
      end
    end
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== p0 + 64'd4) begin
      n_err++;
      $display("FAIL hold_release: got v=%b req=%b addr=%h required v=0 req=1 addr=%h",
               instr_valid_o, imem_req_o, imem_addr_o, p0 + 64'd4);
    end
  endtask

  task automatic test_kill();
    bit ok;
    logic [63:0] old_addr;
    lat_min = 3; lat_max = 3;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_pending(30, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL kill_pending: got timeout required pending req"); end
    old_addr = imem_addr_o;
    drive(1'b1, 1'b1, 2'b01, 64'h10, 26'h3FFFFFE, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== old_addr) begin
      n_err++;
      $display("FAIL kill_no_retract: got req=%b addr=%h required req=1 addr=%h", imem_req_o, imem_addr_o, old_addr);
    end
    wait_valid(40, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h08 || instr_o !== mem_word(64'h08)) begin
      n_err++;
      $display("FAIL kill_target: got ok=%b %h@%h required %h@%h", ok, instr_o, instr_pc_o, mem_word(64'h08), 64'h08);
    end
    // Two taken branches in consecutive cycles: the later one must win.
    wait_pending(30, ok);
    drive(1'b1, 1'b1, 2'b01, 64'h300, 26'h1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b01, 64'h300, 26'h3, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(40, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h30C) begin
      n_err++;
      $display("FAIL back_to_back: got ok=%b pc=%h required pc=%h", ok, instr_pc_o, 64'h30C);
    end
  endtask

  task automatic test_cbz();
    bit ok;
    logic [63:0] nxt;
    lat_min = 0; lat_max = 0;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(20, ok);
    nxt = instr_pc_o + 64'd4;
    drive(1'b1, 1'b1, 2'b10, 64'h200, 26'h4, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL cbz_not_taken: got %b required 0", redirect_o); end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== nxt) begin
      n_err++;
      $display("FAIL cbz_fallthrough: got pc=%h required %h", instr_pc_o, nxt);
    end
    drive(1'b1, 1'b1, 2'b10, 64'h200, 26'h4, 1'b1);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++; if (redirect_o !== 1'b1) begin n_err++; $display("FAIL cbz_taken_pulse: got %b required 1", redirect_o); end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h210) begin
      n_err++;
      $display("FAIL cbz_target: got pc=%h required %h", instr_pc_o, 64'h210);
    end
    // CBNZ with garbage above bit 18: only the 19-bit offset (-1) may count.
    drive(1'b1, 1'b1, 2'b11, 64'h400, 26'h00FFFFF, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h3FC) begin
      n_err++;
      $display("FAIL cbnz_19bit: got pc=%h required %h", instr_pc_o, 64'h3FC);
    end
  endtask

  task automatic test_branch_in_hold();
    bit ok;
    int hs0;
    lat_min = 0; lat_max = 1;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(20, ok);
    hs0 = n_hs;
    drive(1'b1, 1'b1, 2'b01, 64'h1000, 26'h10, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++;
    if (n_hs !== hs0 + 1 || instr_valid_o !== 1'b0 || redirect_o !== 1'b1) begin
      n_err++;
      $display("FAIL hold_ready_branch: got hs=%0d v=%b redir=%b required hs=%0d v=0 redir=1",
               n_hs - hs0, instr_valid_o, redirect_o, 1);
    end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h1040) begin
      n_err++;
      $display("FAIL hold_ready_target: got pc=%h required %h", instr_pc_o, 64'h1040);
    end
    // Taken branch while decode stalls: the held instruction is flushed.
    drive(1'b0, 1'b1, 2'b01, 64'h2000, 26'h3FFFFFC, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b required 0", instr_valid_o); end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 64'h1FF0) begin
      n_err++;
      $display("FAIL flush_target: got pc=%h required %h", instr_pc_o, 64'h1FF0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat_min = 3; lat_max = 3;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_pending(30, ok);
    rst_i = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_drop: got req=%b v=%b required req=0 v=0", imem_req_o, instr_valid_o);
    end
    rst_i = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_err++;
      $display("FAIL reset_mid_restart: got req=%b addr=%h required req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== RESET_PC || instr_o !== mem_word(RESET_PC)) begin
      n_err++;
      $display("FAIL reset_mid_stale_ack: got %h@%h required %h@%h", instr_o, instr_pc_o, mem_word(RESET_PC), RESET_PC);
    end
  endtask

`ifdef BRANCH_LINK_EN
  task automatic test_link();
    bit ok;
    lat_min = 0; lat_max = 0;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    wait_valid(20, ok);
    br_link_i = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 64'h40, 26'h8, 1'b0);
    tick();
    br_link_i = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++;
    if (link_we_o !== 1'b1 || link_data_o !== 64'h44 || redirect_o !== 1'b1) begin
      n_err++;
      $display("FAIL bl_link: got we=%b data=%h redir=%b required we=1 data=44 redir=1", link_we_o, link_data_o, redirect_o);
    end
    tick();
    n_cmp++;
    if (link_we_o !== 1'b0) begin n_err++; $display("FAIL bl_pulse: got %b required 0", link_we_o); end
  endtask
`endif

  task automatic test_random();
    int hs0;
    bit bv;
    hs0 = n_hs;
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      tick();
      bv = ($urandom_range(0, 99) < 15);
      drive($urandom_range(0, 9) < 7, bv, 2'($urandom_range(0, 3)),
            64'($urandom_range(0, 65535)) << 2, 26'($urandom), 1'($urandom_range(0, 1)));
    end
    tick();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);
    n_cmp++;
    if (n_hs - hs0 < 20) begin
      n_err++;
      $display("FAIL random_progress: got %0d handshakes required at least 20", n_hs - hs0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0; n_hs = 0;
    lat_min = 0; lat_max = 0;
    force_ack = 1'b0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    in_idle = 1'b1; prev_taken = 1'b0; prev_hold = 1'b0;
    prev_instr = '0; prev_pc = '0;
    rst_i = 1'b1;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
`ifdef BRANCH_LINK_EN
    br_link_i = 1'b0;
`endif
    drive(1'b1, 1'b0, 2'b00, 64'h0, 26'h0, 1'b0);

    test_reset();
    test_sequential();
    test_hold();
    test_kill();
    test_cbz();
    test_branch_in_hold();
    test_reset_mid();
`ifdef BRANCH_LINK_EN
    test_link();
`endif
    test_random();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
